// File: rtl/mario_death_if.sv
// Bundle between the PIO/frame-timing side and the death sequencer.
// The master side drives the alive byte and the frame tick, and the slave side drives the sprite controls.
interface mario_death_if #(
  parameter int Y_W = 10
);
  logic [7:0]            alive_in;
  logic                  frame_tick;
  logic signed [Y_W-1:0] y_offset;
  logic [1:0]            sprite_sel;
  logic                  freeze;
  logic                  death_done;
  logic [7:0]            death_count;
  logic                  busy;

  modport master (
    output alive_in, frame_tick,
    input  y_offset, sprite_sel, freeze, death_done, death_count, busy
  );

  modport slave (
    input  alive_in, frame_tick,
    output y_offset, sprite_sel, freeze, death_done, death_count, busy
  );
endinterface

// File: rtl/mario_death_sequencer.sv
// Mario death animation sequencer.
// When a death is detected (alive byte goes from nonzero to zero), the sprite freezes in the death pose.
// It then jumps up and falls off screen under gravity, with one motion step per frame tick.
// Reviving at any point snaps everything back to the idle state.
module mario_death_sequencer #(
  parameter int FREEZE_FRAMES = 30,
  parameter int V0            = 6,
  parameter int GRAVITY       = 1,
  parameter int MAX_FALL      = 8,
  parameter int FALL_LIMIT    = 240,
  parameter int Y_W           = 10
) (
  input logic          clk,
  input logic          reset_n,
  mario_death_if.slave bus
);

  typedef enum logic [2:0] {IDLE, FREEZE, RISE, FALL, DONE} state_t;

  localparam logic [8:0]            FF9   = 9'(FREEZE_FRAMES);
  localparam logic signed [7:0]     VEL0  = 8'(-V0);
  localparam logic signed [8:0]     GRAV9 = 9'(GRAVITY);
  localparam logic signed [8:0]     MAXF9 = 9'(MAX_FALL);
  localparam logic signed [Y_W:0]   LIM   = (Y_W+1)'(FALL_LIMIT);
  localparam logic signed [Y_W-1:0] LIM_Y = Y_W'(FALL_LIMIT);

  state_t                state_q, state_d;
  logic                  alive_q, alive_now, dead_edge;
  logic signed [7:0]     vel_q, vel_d, vel_next;
  logic signed [8:0]     vel_sum;
  logic [7:0]            fcnt_q, fcnt_d;
  logic [7:0]            cnt_q, cnt_d;
  logic signed [Y_W-1:0] y_q, y_d;
  logic signed [Y_W:0]   y_sum;
  logic [1:0]            sel_q, sel_d;
  logic                  freeze_q, freeze_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;

  // The PIO resets to zero, so only a registered 1->0 edge counts as a death.
  // Zero out of reset therefore never triggers.
  assign alive_now = |bus.alive_in;
  assign dead_edge = alive_q & ~alive_now;

  // Position and velocity sums are widened by one bit so that the limit compare cannot wrap.
  assign y_sum    = (Y_W+1)'(y_q) + (Y_W+1)'(vel_q);
  assign vel_sum  = 9'(vel_q) + GRAV9;
  assign vel_next = (vel_sum > MAXF9) ? 8'(MAXF9) : 8'(vel_sum);

  // Next-state, datapath and output decode.
  // Revive is applied last so that it overrides any coincident frame tick.
  always_comb begin
    state_d  = state_q;
    y_d      = y_q;
    vel_d    = vel_q;
    fcnt_d   = fcnt_q;
    cnt_d    = cnt_q;
    sel_d    = 2'd0;
    freeze_d = 1'b0;
    done_d   = 1'b0;
    busy_d   = 1'b0;

    case (state_q)
      IDLE: begin
        y_d   = '0;
        vel_d = '0;
        if (dead_edge) begin
          state_d = FREEZE;
          fcnt_d  = '0;
          cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        end
      end
      FREEZE: begin
        if (bus.frame_tick) begin
          fcnt_d = fcnt_q + 8'd1;
          if (9'(fcnt_q) + 9'd1 == FF9) begin
            state_d = RISE;
            vel_d   = VEL0;
            y_d     = '0;
          end
        end
      end
      RISE: begin
        if (bus.frame_tick) begin
          y_d   = Y_W'(y_sum);
          vel_d = vel_next;
          if (vel_next >= 8'sd0) state_d = FALL;
        end
      end
      FALL: begin
        if (bus.frame_tick) begin
          vel_d = vel_next;
          if (y_sum >= LIM) begin
            y_d     = LIM_Y;
            state_d = DONE;
          end else begin
            y_d = Y_W'(y_sum);
          end
        end
      end
      DONE: begin
        y_d = LIM_Y;
      end
      default: begin
        state_d = IDLE;
        y_d     = '0;
        vel_d   = '0;
        fcnt_d  = '0;
      end
    endcase

    if (state_q != IDLE && alive_now) begin
      state_d = IDLE;
      y_d     = '0;
      vel_d   = '0;
      fcnt_d  = '0;
    end

    case (state_d)
      FREEZE, RISE, FALL: begin
        sel_d    = 2'd1;
        freeze_d = 1'b1;
        busy_d   = 1'b1;
      end
      DONE: begin
        sel_d    = 2'd2;
        freeze_d = 1'b1;
        done_d   = 1'b1;
      end
      default: ;
    endcase
  end

  // State, datapath and registered outputs.
  // Reset is asynchronous, so a mid-animation reset clears everything at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      alive_q  <= 1'b0;
      y_q      <= '0;
      vel_q    <= '0;
      fcnt_q   <= '0;
      cnt_q    <= '0;
      sel_q    <= 2'd0;
      freeze_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      alive_q  <= alive_now;
      y_q      <= y_d;
      vel_q    <= vel_d;
      fcnt_q   <= fcnt_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      freeze_q <= freeze_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.y_offset    = y_q;
  assign bus.sprite_sel  = sel_q;
  assign bus.freeze      = freeze_q;
  assign bus.death_done  = done_q;
  assign bus.death_count = cnt_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_mario_death_sequencer.sv
// Directed bench for the death sequencer.
// Each step pushes the output vector expected after the next clock edge.
// That vector is popped and compared once the edge has passed.
module tb_mario_death_sequencer;

  typedef struct packed {
    logic signed [9:0] y;
    logic [1:0]        sel;
    logic              frz;
    logic              done;
    logic              busy;
    logic [7:0]        cnt;
  } out_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  out_t sb[$];

  // Y offsets from the test plan, one per tick after entering RISE, ending in the clamp.
  int ys[13] = '{-4, -7, -9, -10, -10, -9, -7, -4, 0, 5, 11, 17, 20};

  mario_death_if #(.Y_W(10)) bus ();

  mario_death_sequencer #(
    .FREEZE_FRAMES(3), .V0(4), .GRAVITY(1), .MAX_FALL(6), .FALL_LIMIT(20), .Y_W(10)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic out_t mk(input int y, input int sel, input logic frz, input logic done,
                              input logic busy, input int cnt);
    out_t o;
    o.y = 10'(y); o.sel = 2'(sel); o.frz = frz; o.done = done; o.busy = busy; o.cnt = 8'(cnt);
    return o;
  endfunction

  function automatic out_t idle_o(input int cnt);  return mk(0, 0, 0, 0, 0, cnt); endfunction
  function automatic out_t anim_o(input int y, input int cnt); return mk(y, 1, 1, 0, 1, cnt); endfunction
  function automatic out_t done_o(input int cnt);  return mk(20, 2, 1, 1, 0, cnt); endfunction

  task automatic check(input string tag);
    out_t e, obs;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s: observed empty scoreboard required one entry", tag);
      return;
    end
    e = sb.pop_front();
    obs.y = bus.y_offset; obs.sel = bus.sprite_sel; obs.frz = bus.freeze;
    obs.done = bus.death_done; obs.busy = bus.busy; obs.cnt = bus.death_count;
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s: observed %p required %p", tag, obs, e);
    end
  endtask

  task automatic step(input logic [7:0] a, input logic t, input out_t e, input string tag);
    bus.alive_in   = a;
    bus.frame_tick = t;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check(tag);
  endtask

  initial begin
    int cnt;
    bus.alive_in   = 8'h00;
    bus.frame_tick = 1'b0;

    // Reset state
    #12;
    sb.push_back(idle_o(0));
    check("reset");
    reset_n = 1'b1;

    // 1: alive=0 out of reset plus frame ticks stays idle
    for (int i = 0; i < 10; i++) step(8'h00, 1'b1, idle_o(0), "idle_ticks");
    step(8'h01, 1'b0, idle_o(0), "alive_write");

    // 2/3: death, freeze for 3 ticks, then rise and fall to DONE
    step(8'h00, 1'b0, anim_o(0, 1), "death_edge");
    step(8'h00, 1'b0, anim_o(0, 1), "freeze_hold");
    for (int i = 0; i < 3; i++) step(8'h00, 1'b1, anim_o(0, 1), "freeze_tick");
    for (int i = 0; i < 13; i++) begin
      step(8'h00, 1'b1, (i == 12) ? done_o(1) : anim_o(ys[i], 1), "arc");
      if (i < 12) step(8'h00, 1'b0, anim_o(ys[i], 1), "arc_hold");
    end
    step(8'h00, 1'b1, done_o(1), "done_ignores_tick");
    step(8'h05, 1'b0, idle_o(1), "revive_from_done");

    // 4: revive at RISE tick 2 wins over the tick
    step(8'h00, 1'b0, anim_o(0, 2), "death2");
    for (int i = 0; i < 3; i++) step(8'h00, 1'b1, anim_o(0, 2), "freeze2");
    step(8'h00, 1'b1, anim_o(-4, 2), "rise2_t1");
    step(8'h05, 1'b1, idle_o(2), "revive_with_tick");
    step(8'h05, 1'b1, idle_o(2), "idle_after_revive");

    // 6: tick held high, dead-edge tick not counted, DONE 13 cycles after RISE
    step(8'h00, 1'b1, anim_o(0, 3), "death3_tick");
    for (int i = 0; i < 3; i++) step(8'h00, 1'b1, anim_o(0, 3), "freeze3");
    for (int i = 0; i < 13; i++)
      step(8'h00, 1'b1, (i == 12) ? done_o(3) : anim_o(ys[i], 3), "cont_arc");
    step(8'h00, 1'b1, done_o(3), "cont_done_hold");

    // 5: 256 death/revive cycles saturate the counter
    cnt = 3;
    for (int i = 0; i < 256; i++) begin
      step(8'h01, 1'b0, idle_o(cnt), "sat_revive");
      cnt = (cnt < 255) ? cnt + 1 : 255;
      step(8'h00, 1'b0, anim_o(0, cnt), "sat_death");
    end
    step(8'h00, 1'b0, anim_o(0, 255), "sat_final");

    // Reset mid-FALL returns to reset values immediately
    for (int i = 0; i < 3; i++) step(8'h00, 1'b1, anim_o(0, 255), "freeze4");
    for (int i = 0; i < 5; i++) step(8'h00, 1'b1, anim_o(ys[i], 255), "fall4");
    reset_n = 1'b0;
    #1;
    sb.push_back(idle_o(0));
    check("async_reset");
    #3;
    reset_n = 1'b1;
    step(8'h00, 1'b1, idle_o(0), "post_reset_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish required finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mario_death_sequencer.md
Name: mario_death_sequencer

Overview:
- Consumes the 8-bit "mario alive" byte that the Nios II writes through its Avalon PIO output port.
- Detects a nonzero-to-zero (death) transition and runs a frame-timed death animation: freeze, jump up, fall off screen.
- Drives the sprite renderer (Y offset, sprite select), a game-logic freeze flag, a done flag and a saturating death counter.
- Sits between the PIO output port and the VGA sprite/colour mapper, in the clk domain.

Parameters:
- FREEZE_FRAMES, 30, frame ticks held in the death pose before the jump starts (1..255)
- V0, 6, initial upward speed in px/frame; velocity is loaded as -V0 (1..127)
- GRAVITY, 1, velocity increment per frame tick (1..15)
- MAX_FALL, 8, maximum downward velocity in px/frame (clamp)
- FALL_LIMIT, 240, positive Y offset at which the fall ends
- Y_W, 10, width of the signed Y offset

Ports:
- clk  in  1  system clock, same domain as the PIO
- reset_n  in  1  asynchronous, active-low reset
- alive_in  in  8  PIO alive byte; nonzero means alive
- frame_tick  in  1  one-cycle pulse per video frame (VGA vsync edge)
- y_offset  out  Y_W  signed sprite Y offset in px; negative is up
- sprite_sel  out  2  0 = normal, 1 = death pose, 2 = hidden
- freeze  out  1  high halts game motion and scrolling
- death_done  out  1  high while the animation has completed
- death_count  out  8  saturating count of detected deaths
- busy  out  1  high in FREEZE, RISE or FALL

Behaviour:
- Internal registers:
  - alive_q: alive_q <= |alive_in on every clock.
  - dead_edge = alive_q & ~|alive_in, combinational.
  - vel: signed 8-bit velocity.
  - fcnt: 8-bit frame counter.
- Reset values:
  - State IDLE; alive_q = 0; y_offset = 0; vel = 0; fcnt = 0.
  - sprite_sel = 0, freeze = 0, death_done = 0, death_count = 0, busy = 0.
  - The PIO also resets to 0, so alive = 0 out of reset must NOT trigger a death. Only a 1-to-0 edge on alive_q triggers.
- Outputs are registered and decoded from the state.
- A transition taken at edge N is visible in the cycle after edge N.

IDLE
- Outputs: sprite_sel = 0, freeze = 0, y_offset = 0.
- On dead_edge:
  - Go to FREEZE.
  - Clear fcnt.
  - Increment death_count, saturating at 255.
- A frame_tick in the same cycle as dead_edge is not counted.

FREEZE
- Outputs: sprite_sel = 1, freeze = 1, busy = 1.
- Each frame_tick increments fcnt.
- On the tick where fcnt + 1 == FREEZE_FRAMES:
  - Go to RISE.
  - Load vel = -V0 and y_offset = 0; no movement on that tick.

RISE / FALL
- Outputs: sprite_sel = 1, freeze = 1, busy = 1.
- Each frame_tick:
  - y_offset <= y_offset + vel.
  - vel <= min(vel + GRAVITY, MAX_FALL).
- RISE -> FALL on the tick where the new vel is >= 0 (apex).
- FALL -> DONE on the tick where y_offset + vel >= FALL_LIMIT; y_offset is clamped to FALL_LIMIT.
- All arithmetic is signed. The sum is formed at Y_W+1 bits before the compare and clamp, so there is no wrap.

DONE
- Outputs: sprite_sel = 2, freeze = 1, death_done = 1, busy = 0; y_offset holds FALL_LIMIT.

Revive
- Whenever |alive_in == 1 in any non-IDLE state, go to IDLE on the next edge.
- y_offset, vel and fcnt clear, and the outputs return to IDLE values.
- Revive has priority over a coincident frame_tick.

Other rules
- A dead_edge cannot occur outside IDLE: alive_q must first return to 1, which forces IDLE.
- frame_tick is ignored in IDLE and DONE.
- Asserting reset_n low mid-animation returns everything to reset values immediately. death_count clears.

Test Plan:
Parameters for all scenarios: FREEZE_FRAMES=3, V0=4, GRAVITY=1, MAX_FALL=6, FALL_LIMIT=20.
1. Release reset with alive_in=0 and run 10 frame_ticks -> stays IDLE, freeze=0, death_count=0. Then write alive_in=0x01 -> still IDLE.
2. alive 0x01 -> 0x00 -> FREEZE next cycle: sprite_sel=1, freeze=1, death_count=1. After 3 ticks -> RISE with y=0, vel=-4.
3. Continue ticking:
   - RISE y sequence -4, -7, -9, -10; FALL is entered after tick 4 (vel=0).
   - FALL y sequence -10, -9, -7, -4, 0, 5, 11, 17, then clamp 20; vel saturates at 6.
   - Ends in DONE: death_done=1, sprite_sel=2.
4. alive_in=0x05 at RISE tick 2, coinciding with a frame_tick -> IDLE next cycle: y_offset=0, freeze=0, death_done=0. The tick has no effect.
5. Drive 256 death/revive cycles -> death_count saturates at 255. Pulse reset_n low mid-FALL -> immediate IDLE, all outputs 0.
6. frame_tick held high continuously through the death sequence -> one step per cycle and the same y sequence as scenario 3. DONE is reached 13 cycles after entering RISE.
